mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_pkg.sv | 19 +
 rtl/mem_wb_stage_regs.sv | 30 +++
 rtl/mem_wb_stage.sv | 151 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: FSM encoding, timeout default,
// and the word-alignment helper.
package mem_wb_stage_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } stageState_t;

  localparam int DEFAULT_MAX_WAIT_CYCLES = 15;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic isWordAligned(input logic [1:0] lowAddressBits);
    return (lowAddressBits & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_stage_regs.sv
// MEM/WB pipeline register. A bubble squashes the write enable while the
// address/data fields hold, and register 0 is never written.
module MemWbRegisters (
  input  logic        clock,
  input  logic        reset,
  input  logic        bubble,
  input  logic        shouldWriteRegister,
  input  logic [4:0]  registerWriteAddress,
  input  logic [31:0] registerWriteData,
  output logic        wb_shouldWriteRegister,
  output logic [4:0]  wb_registerWriteAddress,
  output logic [31:0] wb_registerWriteData
);

  // Capture the retiring instruction, or insert a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_shouldWriteRegister  <= 1'b0;
      wb_registerWriteAddress <= 5'd0;
      wb_registerWriteData    <= 32'd0;
    end else if (bubble) begin
      wb_shouldWriteRegister  <= 1'b0;
    end else begin
      wb_shouldWriteRegister  <= shouldWriteRegister && (registerWriteAddress != 5'd0);
      wb_registerWriteAddress <= registerWriteAddress;
      wb_registerWriteData    <= registerWriteData;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: issues data-memory accesses through a request/ready
// handshake, stalls upstream while waiting, times out on a silent memory,
// and feeds the write-back pipeline register.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int MAX_WAIT_CYCLES = DEFAULT_MAX_WAIT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_shouldWriteRegister,
  input  logic [4:0]  mem_registerWriteAddress,
  input  logic        mem_shouldWriteMemoryElseAluOutputToRegister,
  input  logic [31:0] mem_aluOutput,
  input  logic        mem_shouldWriteMemory,
  input  logic [31:0] mem_registerRtOrZero,
  output logic        dmem_request,
  output logic        dmem_writeEnable,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_writeData,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_readData,
  output logic        mem_stall,
  output logic        wb_shouldWriteRegister,
  output logic [4:0]  wb_registerWriteAddress,
  output logic [31:0] wb_registerWriteData,
  output logic        mem_misaligned,
  output logic        mem_busError
);

  localparam int COUNT_WIDTH = (MAX_WAIT_CYCLES < 1) ? 1 : $clog2(MAX_WAIT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_WAIT_CYCLES);

  stageState_t            stateReg, stateNext;
  logic [COUNT_WIDTH-1:0] waitCountReg, waitCountNext;
  logic                   requestReg, requestNext;
  logic                   writeEnableReg, writeEnableNext;
  logic [31:0]            addressReg, addressNext;
  logic [31:0]            writeDataReg, writeDataNext;
  logic                   misalignedReg, misalignedNext;
  logic                   busErrorReg, busErrorNext;
  logic                   stallComb;
  logic                   wbBubble;
  logic [31:0]            wbWriteData;

  // Instruction decode. Both memory flags set means "store, no write-back".
  logic isMemOp, isLoad, writeBackAllowed, accessAligned;
  assign isMemOp          = mem_shouldWriteMemory | mem_shouldWriteMemoryElseAluOutputToRegister;
  assign isLoad           = mem_shouldWriteMemoryElseAluOutputToRegister & ~mem_shouldWriteMemory;
  assign writeBackAllowed = mem_shouldWriteRegister
                          & ~(mem_shouldWriteMemory & mem_shouldWriteMemoryElseAluOutputToRegister);
  assign accessAligned    = isWordAligned(mem_aluOutput[1:0]);

  // Next-state, handshake and write-back selection.
  always_comb begin
    stateNext       = stateReg;
    waitCountNext   = waitCountReg;
    requestNext     = requestReg;
    writeEnableNext = writeEnableReg;
    addressNext     = addressReg;
    writeDataNext   = writeDataReg;
    misalignedNext  = 1'b0;
    busErrorNext    = busErrorReg;
    stallComb       = 1'b0;
    wbBubble        = 1'b1;
    wbWriteData     = mem_aluOutput;

    case (stateReg)
      IDLE: begin
        // dmem_ready is deliberately not looked at here.
        if (!isMemOp) begin
          wbBubble = 1'b0;
        end else if (accessAligned) begin
          stallComb       = 1'b1;
          stateNext       = WAIT;
          waitCountNext   = '0;
          requestNext     = 1'b1;
          writeEnableNext = mem_shouldWriteMemory;
          addressNext     = mem_aluOutput;
          writeDataNext   = mem_registerRtOrZero;
        end else begin
          misalignedNext = 1'b1;
        end
      end
      WAIT: begin
        // Ready wins over the timeout when both land in the same cycle.
        if (dmem_ready) begin
          stateNext   = IDLE;
          requestNext = 1'b0;
          wbBubble    = 1'b0;
          wbWriteData = isLoad ? dmem_readData : mem_aluOutput;
        end else if (waitCountReg == MAX_COUNT) begin
          stateNext    = IDLE;
          requestNext  = 1'b0;
          busErrorNext = 1'b1;
        end else begin
          stallComb     = 1'b1;
          waitCountNext = waitCountReg + 1'b1;
        end
      end
      default: begin
        stateNext   = IDLE;
        requestNext = 1'b0;
      end
    endcase
  end

  // State, counter and dmem interface registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg       <= IDLE;
      waitCountReg   <= '0;
      requestReg     <= 1'b0;
      writeEnableReg <= 1'b0;
      addressReg     <= 32'd0;
      writeDataReg   <= 32'd0;
      misalignedReg  <= 1'b0;
      busErrorReg    <= 1'b0;
    end else begin
      stateReg       <= stateNext;
      waitCountReg   <= waitCountNext;
      requestReg     <= requestNext;
      writeEnableReg <= writeEnableNext;
      addressReg     <= addressNext;
      writeDataReg   <= writeDataNext;
      misalignedReg  <= misalignedNext;
      busErrorReg    <= busErrorNext;
    end
  end

  assign dmem_request     = requestReg;
  assign dmem_writeEnable = writeEnableReg;
  assign dmem_address     = addressReg;
  assign dmem_writeData   = writeDataReg;
  assign mem_misaligned   = misalignedReg;
  assign mem_busError     = busErrorReg;
  assign mem_stall        = stallComb;

  MemWbRegisters wbRegisters (
    .clock                  (clock),
    .reset                  (reset),
    .bubble                 (wbBubble),
    .shouldWriteRegister    (writeBackAllowed),
    .registerWriteAddress   (mem_registerWriteAddress),
    .registerWriteData      (wbWriteData),
    .wb_shouldWriteRegister (wb_shouldWriteRegister),
    .wb_registerWriteAddress(wb_registerWriteAddress),
    .wb_registerWriteData   (wb_registerWriteData)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU pass-through, loads, stores,
// misalignment, timeout boundary and reset during an access.
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_shouldWriteRegister;
  logic [4:0]  mem_registerWriteAddress;
  logic        mem_shouldWriteMemoryElseAluOutputToRegister;
  logic [31:0] mem_aluOutput;
  logic        mem_shouldWriteMemory;
  logic [31:0] mem_registerRtOrZero;
  logic        dmem_request;
  logic        dmem_writeEnable;
  logic [31:0] dmem_address;
  logic [31:0] dmem_writeData;
  logic        dmem_ready;
  logic [31:0] dmem_readData;
  logic        mem_stall;
  logic        wb_shouldWriteRegister;
  logic [4:0]  wb_registerWriteAddress;
  logic [31:0] wb_registerWriteData;
  logic        mem_misaligned;
  logic        mem_busError;

  int total = 0;
  int bad   = 0;
  int stallCycles;

  mem_wb_stage #(.MAX_WAIT_CYCLES(15)) dut (
    .clock                                       (clock),
    .reset                                       (reset),
    .mem_shouldWriteRegister                     (mem_shouldWriteRegister),
    .mem_registerWriteAddress                    (mem_registerWriteAddress),
    .mem_shouldWriteMemoryElseAluOutputToRegister(mem_shouldWriteMemoryElseAluOutputToRegister),
    .mem_aluOutput                               (mem_aluOutput),
    .mem_shouldWriteMemory                       (mem_shouldWriteMemory),
    .mem_registerRtOrZero                        (mem_registerRtOrZero),
    .dmem_request                                (dmem_request),
    .dmem_writeEnable                            (dmem_writeEnable),
    .dmem_address                                (dmem_address),
    .dmem_writeData                              (dmem_writeData),
    .dmem_ready                                  (dmem_ready),
    .dmem_readData                               (dmem_readData),
    .mem_stall                                   (mem_stall),
    .wb_shouldWriteRegister                      (wb_shouldWriteRegister),
    .wb_registerWriteAddress                     (wb_registerWriteAddress),
    .wb_registerWriteData                        (wb_registerWriteData),
    .mem_misaligned                              (mem_misaligned),
    .mem_busError                                (mem_busError)
  );

  always #5 clock = ~clock;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setOp(input logic wr, input logic [4:0] dest, input logic load,
                       input logic store, input logic [31:0] alu, input logic [31:0] rt);
    mem_shouldWriteRegister                      = wr;
    mem_registerWriteAddress                     = dest;
    mem_shouldWriteMemoryElseAluOutputToRegister = load;
    mem_shouldWriteMemory                        = store;
    mem_aluOutput                                = alu;
    mem_registerRtOrZero                         = rt;
  endtask

  initial begin
    reset = 1'b1;
    dmem_ready = 1'b0;
    dmem_readData = 32'd0;
    setOp(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    check("rst_request", {31'd0, dmem_request}, 32'd0);
    check("rst_wb_en", {31'd0, wb_shouldWriteRegister}, 32'd0);
    check("rst_wb_data", wb_registerWriteData, 32'd0);
    check("rst_address", dmem_address, 32'd0);
    check("rst_buserr", {31'd0, mem_busError}, 32'd0);
    check("rst_misaligned", {31'd0, mem_misaligned}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    reset = 1'b0;
    tick();

    // ALU op: passes straight through in one cycle, never stalls.
    setOp(1'b1, 5'd5, 1'b0, 1'b0, 32'h0000_1234, 32'd0);
    #1 check("alu_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("alu_wb_en", {31'd0, wb_shouldWriteRegister}, 32'd1);
    check("alu_wb_addr", {27'd0, wb_registerWriteAddress}, 32'd5);
    check("alu_wb_data", wb_registerWriteData, 32'h0000_1234);
    check("alu_stall_after", {31'd0, mem_stall}, 32'd0);
    $display("txn alu dest=5 data=%h", wb_registerWriteData);

    // Writes to register 0 are suppressed.
    setOp(1'b1, 5'd0, 1'b0, 1'b0, 32'h0000_0055, 32'd0);
    tick();
    check("r0_wb_en", {31'd0, wb_shouldWriteRegister}, 32'd0);
    $display("txn alu dest=0 suppressed");

    // Load at 0x100: 3 WAIT cycles without ready, ready on the 4th.
    setOp(1'b1, 5'd7, 1'b1, 1'b0, 32'h0000_0100, 32'd0);
    stallCycles = 0;
    #1 if (mem_stall) stallCycles++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_stall) stallCycles++;
      check("ld_request", {31'd0, dmem_request}, 32'd1);
      check("ld_address", dmem_address, 32'h0000_0100);
      check("ld_wb_bubble", {31'd0, wb_shouldWriteRegister}, 32'd0);
    end
    tick();
    check("ld_address_last", dmem_address, 32'h0000_0100);
    check("ld_we", {31'd0, dmem_writeEnable}, 32'd0);
    dmem_ready = 1'b1;
    dmem_readData = 32'hDEAD_BEEF;
    #1 check("ld_stall_ready", {31'd0, mem_stall}, 32'd0);
    check("ld_stall_count", stallCycles, 32'd4);
    tick();
    dmem_ready = 1'b0;
    check("ld_request_drop", {31'd0, dmem_request}, 32'd0);
    check("ld_wb_en", {31'd0, wb_shouldWriteRegister}, 32'd1);
    check("ld_wb_addr", {27'd0, wb_registerWriteAddress}, 32'd7);
    check("ld_wb_data", wb_registerWriteData, 32'hDEAD_BEEF);
    $display("txn load addr=100 dest=7 data=%h", wb_registerWriteData);

    // Store at 0x40 with ready in the first WAIT cycle, no write-back.
    setOp(1'b0, 5'd3, 1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5);
    #1 check("st_stall_entry", {31'd0, mem_stall}, 32'd1);
    tick();
    check("st_request", {31'd0, dmem_request}, 32'd1);
    check("st_we", {31'd0, dmem_writeEnable}, 32'd1);
    check("st_wdata", dmem_writeData, 32'hA5A5_A5A5);
    check("st_address", dmem_address, 32'h0000_0040);
    dmem_ready = 1'b1;
    #1 check("st_stall_ready", {31'd0, mem_stall}, 32'd0);
    tick();
    check("st_request_drop", {31'd0, dmem_request}, 32'd0);
    check("st_wb_en", {31'd0, wb_shouldWriteRegister}, 32'd0);
    $display("txn store addr=40 data=a5a5a5a5");

    // Back-to-back store that also writes a register: write-back is aluOutput.
    setOp(1'b1, 5'd9, 1'b0, 1'b1, 32'h0000_0048, 32'h0000_1111);
    tick();
    check("st2_request", {31'd0, dmem_request}, 32'd1);
    tick();
    check("st2_wb_en", {31'd0, wb_shouldWriteRegister}, 32'd1);
    check("st2_wb_data", wb_registerWriteData, 32'h0000_0048);
    $display("txn store+wb addr=48 dest=9");

    // Both memory flags: behaves as a store, no write-back.
    setOp(1'b1, 5'd10, 1'b1, 1'b1, 32'h0000_0044, 32'h0000_0077);
    tick();
    check("both_we", {31'd0, dmem_writeEnable}, 32'd1);
    check("both_wdata", dmem_writeData, 32'h0000_0077);
    tick();
    dmem_ready = 1'b0;
    check("both_wb_en", {31'd0, wb_shouldWriteRegister}, 32'd0);
    $display("txn load+store addr=44 treated as store");

    // Misaligned load at 0x102.
    setOp(1'b1, 5'd7, 1'b1, 1'b0, 32'h0000_0102, 32'd0);
    #1 check("mis_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    setOp(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("mis_request", {31'd0, dmem_request}, 32'd0);
    check("mis_pulse", {31'd0, mem_misaligned}, 32'd1);
    check("mis_wb_en", {31'd0, wb_shouldWriteRegister}, 32'd0);
    tick();
    check("mis_pulse_end", {31'd0, mem_misaligned}, 32'd0);
    $display("txn misaligned load addr=102");

    // Timeout: counter runs 0..15; stall for WAIT cycles with count 0..14,
    // then the count==15 cycle releases and flags the error.
    setOp(1'b1, 5'd4, 1'b1, 1'b0, 32'h0000_0200, 32'd0);
    tick();
    stallCycles = 0;
    for (int i = 0; i < 15; i++) begin
      if (mem_stall) stallCycles++;
      tick();
    end
    check("to_stall_count", stallCycles, 32'd15);
    check("to_request_last", {31'd0, dmem_request}, 32'd1);
    check("to_stall_last", {31'd0, mem_stall}, 32'd0);
    check("to_buserr_before", {31'd0, mem_busError}, 32'd0);
    tick();
    setOp(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("to_request_drop", {31'd0, dmem_request}, 32'd0);
    check("to_buserr", {31'd0, mem_busError}, 32'd1);
    check("to_wb_en", {31'd0, wb_shouldWriteRegister}, 32'd0);
    tick();
    tick();
    check("to_buserr_sticky", {31'd0, mem_busError}, 32'd1);
    $display("txn load addr=200 timeout");

    // Reset clears the sticky error.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_buserr", {31'd0, mem_busError}, 32'd0);

    // Ready arriving exactly when the counter hits 15 completes normally.
    setOp(1'b1, 5'd6, 1'b1, 1'b0, 32'h0000_0300, 32'd0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    dmem_ready = 1'b1;
    dmem_readData = 32'h1234_5678;
    #1 check("edge_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    dmem_ready = 1'b0;
    setOp(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("edge_buserr", {31'd0, mem_busError}, 32'd0);
    check("edge_wb_en", {31'd0, wb_shouldWriteRegister}, 32'd1);
    check("edge_wb_data", wb_registerWriteData, 32'h1234_5678);
    $display("txn load addr=300 ready at count 15 data=%h", wb_registerWriteData);

    // Reset in the 2nd WAIT cycle, with ready also high: reset wins.
    setOp(1'b1, 5'd8, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0099);
    tick();
    tick();
    reset = 1'b1;
    dmem_ready = 1'b1;
    dmem_readData = 32'hCAFE_F00D;
    tick();
    reset = 1'b0;
    dmem_ready = 1'b0;
    setOp(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("wrst_request", {31'd0, dmem_request}, 32'd0);
    check("wrst_address", dmem_address, 32'd0);
    check("wrst_we", {31'd0, dmem_writeEnable}, 32'd0);
    check("wrst_wdata", dmem_writeData, 32'd0);
    check("wrst_wb_en", {31'd0, wb_shouldWriteRegister}, 32'd0);
    check("wrst_wb_data", wb_registerWriteData, 32'd0);
    #1 check("wrst_stall", {31'd0, mem_stall}, 32'd0);
    $display("txn load addr=80 abandoned by reset");

    // Back in IDLE: ALU op passes in one cycle and ready is ignored.
    setOp(1'b1, 5'd2, 1'b0, 1'b0, 32'h0000_0ABC, 32'd0);
    dmem_ready = 1'b1;
    dmem_readData = 32'hFFFF_FFFF;
    tick();
    dmem_ready = 1'b0;
    check("idle_wb_en", {31'd0, wb_shouldWriteRegister}, 32'd1);
    check("idle_wb_data", wb_registerWriteData, 32'h0000_0ABC);
    check("idle_request", {31'd0, dmem_request}, 32'd0);
    $display("txn alu dest=2 data=%h ready ignored", wb_registerWriteData);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
